// File: rtl/qsm_dim_master.sv
// qsm_dim_master: QSPI master that sends the DIM reset state, reads registers
// 0..last_reg from a daisy chain of up to 15 DIM devices and fills the readout SRAM.
// Ports: clk_i/rst_i (sync, active-high); ctrl_* pulses and latched settings;
//   busy_o/done_o/err_many_o/err_fb_o/dim_count_o status; sck_o/ss_o/sdi_i/fb_i
//   serial chain; mem_we_o/mem_addr_o {dev,reg}/mem_data_o SRAM write port.
// Optional: define QSM_ABORT_EN to let ctrl_reset_i abort a running readout.
module qsm_dim_master #(
   parameter int CLK_DIV  = 50,
   parameter int US_TICKS = 100,
   parameter int RESET_US = 100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ctrl_reset_i,
   input  logic        ctrl_trig_i,
   input  logic [3:0]  ctrl_last_reg_i,
   input  logic [3:0]  ctrl_max_dim_i,
   input  logic [9:0]  ctrl_delay_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_many_o,
   output logic        err_fb_o,
   output logic [3:0]  dim_count_o,
   output logic        sck_o,
   output logic        ss_o,
   input  logic        sdi_i,
   input  logic        fb_i,
   output logic        mem_we_o,
   output logic [7:0]  mem_addr_o,
   output logic [15:0] mem_data_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_SHIFT, S_WRITE, S_DELAY, S_DONE
   } state_t;

   localparam logic [31:0] HALF     = 32'(CLK_DIV);
   localparam logic [31:0] PER_LAST = 32'(2 * CLK_DIV - 1);
   localparam logic [31:0] RST_LAST = 32'(RESET_US * US_TICKS - 1);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  bit_q, bit_d;
   logic [3:0]  dev_q, dev_d;
   logic [3:0]  reg_q, reg_d;
   logic [3:0]  last_q, last_d;
   logic [3:0]  max_q, max_d;
   logic [3:0]  dim_q, dim_d;
   logic [9:0]  dly_q, dly_d;
   logic [15:0] sh_q, sh_d;
   logic        fb_q, fb_d;
   logic        done_q, done_d;
   logic        many_q, many_d;
   logic        efb_q, efb_d;

   logic        abort;
   logic [4:0]  nxt;
   logic [31:0] wait_cyc;

`ifdef QSM_ABORT_EN
   assign abort = ctrl_reset_i &&
                  (state_q == S_SHIFT || state_q == S_WRITE || state_q == S_DELAY);
`else
   assign abort = 1'b0;
`endif

   assign nxt = {1'b0, dev_q} + 5'd1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      dev_d    = dev_q;
      reg_d    = reg_q;
      last_d   = last_q;
      max_d    = max_q;
      dim_d    = dim_q;
      dly_d    = dly_q;
      sh_d     = sh_q;
      fb_d     = fb_q;
      done_d   = done_q;
      many_d   = many_q;
      efb_d    = efb_q;
      // a zero delay setting still spends one cycle with ss low
      wait_cyc = 32'(dly_q) * 32'(US_TICKS);
      if (wait_cyc == 32'd0) wait_cyc = 32'd1;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = 32'd0;
            bit_d = 4'd15;
            if (ctrl_reset_i) begin
               done_d  = 1'b0;
               state_d = S_RST;
            end else if (ctrl_trig_i) begin
               done_d = 1'b0;
               many_d = 1'b0;
               efb_d  = 1'b0;
               dim_d  = 4'd0;
               last_d = ctrl_last_reg_i;
               max_d  = ctrl_max_dim_i;
               dly_d  = ctrl_delay_i;
               reg_d  = 4'd0;
               dev_d  = 4'd0;
               if (ctrl_max_dim_i == 4'd0) begin
                  many_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_RST: begin
            if (cnt_q == RST_LAST) begin
               cnt_d   = 32'd0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_SHIFT: begin
            cnt_d = cnt_q + 32'd1;
            // first high cycle of sck: capture the bit
            if (cnt_q == HALF) begin
               sh_d = {sh_q[14:0], sdi_i};
               if (bit_q == 4'd0) fb_d = fb_i;
            end
            if (cnt_q == PER_LAST) begin
               cnt_d = 32'd0;
               if (bit_q == 4'd0) state_d = S_WRITE;
               else               bit_d = bit_q - 4'd1;
            end
         end
         S_WRITE: begin
            bit_d = 4'd15;
            cnt_d = 32'd0;
            if (reg_q == 4'd0) begin
               if (fb_q) begin
                  if (nxt >= {1'b0, max_q}) begin
                     many_d  = 1'b1;
                     dim_d   = max_q;
                     state_d = S_DONE;
                  end else begin
                     dev_d   = nxt[3:0];
                     state_d = S_SHIFT;
                  end
               end else begin
                  dim_d   = nxt[3:0];
                  state_d = S_DELAY;
               end
            end else if (fb_q != (nxt < {1'b0, dim_q})) begin
               efb_d   = 1'b1;
               state_d = S_DONE;
            end else if (fb_q) begin
               dev_d   = nxt[3:0];
               state_d = S_SHIFT;
            end else begin
               state_d = S_DELAY;
            end
         end
         S_DELAY: begin
            if (reg_q == last_q) begin
               state_d = S_DONE;
            end else if (cnt_q == wait_cyc - 32'd1) begin
               cnt_d   = 32'd0;
               reg_d   = reg_q + 4'd1;
               dev_d   = 4'd0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         cnt_d   = 32'd0;
         done_d  = 1'b0;
         state_d = S_RST;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 32'd0;
         bit_q   <= 4'd15;
         dev_q   <= 4'd0;
         reg_q   <= 4'd0;
         last_q  <= 4'd0;
         max_q   <= 4'd0;
         dim_q   <= 4'd0;
         dly_q   <= 10'd0;
         sh_q    <= 16'd0;
         fb_q    <= 1'b0;
         done_q  <= 1'b0;
         many_q  <= 1'b0;
         efb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         dev_q   <= dev_d;
         reg_q   <= reg_d;
         last_q  <= last_d;
         max_q   <= max_d;
         dim_q   <= dim_d;
         dly_q   <= dly_d;
         sh_q    <= sh_d;
         fb_q    <= fb_d;
         done_q  <= done_d;
         many_q  <= many_d;
         efb_q   <= efb_d;
      end
   end

   assign busy_o      = (state_q == S_RST) || (state_q == S_SHIFT) ||
                        (state_q == S_WRITE) || (state_q == S_DELAY);
   assign done_o      = done_q;
   assign err_many_o  = many_q;
   assign err_fb_o    = efb_q;
   assign dim_count_o = dim_q;
   assign sck_o       = (state_q == S_RST) ||
                        ((state_q == S_SHIFT) && (cnt_q >= HALF));
   // ss spans the whole chain transfer of one register
   assign ss_o        = (state_q == S_SHIFT) || (state_q == S_WRITE);
   assign mem_we_o    = (state_q == S_WRITE) && !abort;
   assign mem_addr_o  = {dev_q, reg_q};
   assign mem_data_o  = sh_q;

endmodule

// File: tb/tb_qsm_dim_master.sv
// tb_qsm_dim_master: randomized and directed checks of qsm_dim_master against
// a chain responder and a word-level readout model.
module tb_qsm_dim_master;

   localparam int CLK_DIV  = 2;
   localparam int US_TICKS = 4;
   localparam int RESET_US = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        creset = 1'b0;
   logic        ctrig = 1'b0;
   logic [3:0]  clast = '0;
   logic [3:0]  cmax = '0;
   logic [9:0]  cdly = '0;
   logic        busy, done, many, efb, sck, ss, we;
   logic [3:0]  dim;
   logic [7:0]  addr;
   logic [15:0] data;
   logic        sdi = 1'b0;
   logic        fb = 1'b0;

   always #5 clk = ~clk;

   qsm_dim_master #(
      .CLK_DIV(CLK_DIV), .US_TICKS(US_TICKS), .RESET_US(RESET_US)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .ctrl_reset_i(creset), .ctrl_trig_i(ctrig),
      .ctrl_last_reg_i(clast), .ctrl_max_dim_i(cmax), .ctrl_delay_i(cdly),
      .busy_o(busy), .done_o(done), .err_many_o(many), .err_fb_o(efb),
      .dim_count_o(dim), .sck_o(sck), .ss_o(ss), .sdi_i(sdi), .fb_i(fb),
      .mem_we_o(we), .mem_addr_o(addr), .mem_data_o(data)
   );

   int checks = 0;
   int failures = 0;

   logic [15:0] words[16][16];
   logic        fbt[16][16];
   int          regcnt = 0;
   logic [23:0] got_q[$];
   logic [23:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // chain responder: presents the bit for the current sck period
   initial begin : chain
      int bitcnt, w, r;
      logic psck, pss;
      bitcnt = 0; psck = 1'b0; pss = 1'b0;
      forever begin
         @(negedge clk);
         if (pss && !ss) regcnt++;
         pss = ss;
         if (!ss) bitcnt = 0;
         else if (psck && !sck) bitcnt++;
         psck = sck;
         w = bitcnt / 16;
         if (w > 15) w = 15;
         r = (regcnt > 15) ? 15 : regcnt;
         sdi = words[r][w][15 - (bitcnt % 16)];
         fb  = fbt[r][w];
      end
   end

   initial begin : mon
      forever begin
         @(negedge clk);
         if (we) got_q.push_back({addr, data});
      end
   end

   task automatic set_chain(input int n, input bit rnd);
      for (int r = 0; r < 16; r++)
         for (int d = 0; d < 16; d++) begin
            fbt[r][d]   = (d < n - 1);
            words[r][d] = rnd ? 16'($urandom) : 16'(16'hA5A0 + r * 3 + d);
         end
   endtask

   // readout rules at word level: what gets written and which flags end up set
   task automatic model(input logic [3:0] lr, input logic [3:0] mx,
                        output logic em, output logic ef,
                        output logic [3:0] ed);
      em = 1'b0; ef = 1'b0; ed = 4'd0;
      exp_q.delete();
      if (mx == 4'd0) begin
         em = 1'b1;
         return;
      end
      for (int r = 0; r <= int'(lr); r++) begin
         for (int d = 0; d < 15; d++) begin
            exp_q.push_back({4'(d), 4'(r), words[r][d]});
            if (r == 0) begin
               if (fbt[r][d]) begin
                  if (d + 1 >= int'(mx)) begin
                     em = 1'b1; ed = mx;
                     return;
                  end
               end else begin
                  ed = 4'(d + 1);
                  break;
               end
            end else begin
               if (fbt[r][d] != (d + 1 < int'(ed))) begin
                  ef = 1'b1;
                  return;
               end
               if (!fbt[r][d]) break;
            end
         end
      end
   endtask

   task automatic start(input logic [3:0] lr, input logic [3:0] mx,
                        input logic [9:0] dl);
      @(posedge clk); #1;
      regcnt = 0;
      got_q.delete();
      clast = lr; cmax = mx; cdly = dl; ctrig = 1'b1;
      @(posedge clk); #1;
      ctrig = 1'b0;
      clast = 4'($urandom); cmax = 4'($urandom); cdly = 10'($urandom);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 6000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic finish_trial(input string tag, input logic em,
                               input logic ef, input logic [3:0] ed);
      int nw;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_nw"}, got_q.size(), exp_q.size());
      nw = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nw; i++)
         chk({tag, "_wr"}, 32'(got_q[i]), 32'(exp_q[i]));
      chk({tag, "_many"}, 32'(many), 32'(em));
      chk({tag, "_efb"}, 32'(efb), 32'(ef));
      chk({tag, "_dim"}, 32'(dim), 32'(ed));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic run_trial(input string tag, input logic [3:0] lr,
                            input logic [3:0] mx, input logic [9:0] dl);
      logic em, ef;
      logic [3:0] ed;
      int n;
      model(lr, mx, em, ef, ed);
      start(lr, mx, dl);
      wait_done(n);
      if (mx == 4'd0) chk({tag, "_lat"}, n, 2);
      finish_trial(tag, em, ef, ed);
   endtask

   initial begin
      int sckc, busyc, ph, gap, n, nwr;
      logic em, ef;
      logic [3:0] ed;
      set_chain(1, 1'b0);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_stat", {busy, done, many, efb, dim, sck, ss, we}, 32'd0);
      chk("rst_mem", {addr, data}, 32'd0);

      set_chain(3, 1'b0);
      run_trial("t2", 4'd1, 4'd4, 10'd0);
      chk("t2_cnt", got_q.size(), 6);

      set_chain(3, 1'b0);
      run_trial("t3", 4'd0, 4'd2, 10'd0);

      set_chain(3, 1'b0);
      fbt[1][0] = 1'b0;
      run_trial("t4", 4'd1, 4'd4, 10'd1);
      chk("t4_cnt", got_q.size(), 4);

      run_trial("max0", 4'd2, 4'd0, 10'd0);

      @(posedge clk); #1 creset = 1'b1;
      @(posedge clk); #1 creset = 1'b0;
      sckc = 0; busyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         busyc++;
         if (sck) sckc++;
      end
      chk("t5_sck", sckc, RESET_US * US_TICKS);
      chk("t5_busy", busyc, RESET_US * US_TICKS);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_idle", {sck, ss}, 32'd0);

      set_chain(1, 1'b1);
      model(4'd1, 4'd2, em, ef, ed);
      start(4'd1, 4'd2, 10'd3);
      ph = 0; gap = 0;
      for (int i = 0; i < 3000 && ph < 3; i++) begin
         @(negedge clk);
         case (ph)
            0: if (ss) ph = 1;
            1: if (!ss) begin ph = 2; gap = 1; end
            2: if (ss) ph = 3; else gap++;
            default: ph = 3;
         endcase
      end
      chk("t6_gap", gap, 3 * US_TICKS);
      wait_done(n);
      finish_trial("t6", em, ef, ed);

      for (int t = 0; t < 20; t++) begin
         logic [3:0] lr, mx;
         logic [9:0] dl;
         set_chain($urandom_range(1, 6), 1'b1);
         lr = 4'($urandom_range(0, 3));
         mx = 4'($urandom_range(0, 7));
         dl = 10'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) begin
            int rr, dd;
            rr = $urandom_range(1, 3);
            dd = $urandom_range(0, 5);
            fbt[rr][dd] = !fbt[rr][dd];
         end
         run_trial("rnd", lr, mx, dl);
      end

`ifdef QSM_ABORT_EN
      set_chain(4, 1'b1);
      start(4'd3, 4'd6, 10'd0);
      for (int i = 0; i < 200 && !ss; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      @(posedge clk); #1 creset = 1'b1;
      @(posedge clk); #1 creset = 1'b0;
      @(negedge clk);
      chk("ab_ss", 32'(ss), 32'd0);
      nwr = got_q.size();
      repeat (100) @(negedge clk);
      chk("ab_we", got_q.size(), nwr);
      chk("ab_done", 32'(done), 32'd0);
`else
      nwr = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
